aes_key_sched_iter: RTL and testbench
=====================================

// Module: aes_key_sched_iter
// PURPOSE
//  Iterative AES-128 key schedule engine; walks the schedule one round per cycle.
//  Forward mode: cipher key -> round-10 key, the start key for a decryption pass.
//  Inverse mode: round-10 key -> cipher key.
//  Sits beside the per-round key expander. It precomputes or recovers the full-key
//  end point before a cipher run. Uses one 4-byte forward S-box word (aes_sbox).
// PARAMETERS
//  SBoxImpl  "lut"  S-box implementation, passed through to the 4 aes_sbox instances
// PORTS
//  clk_i        in   1    clock
//  rst_i        in   1    synchronous active-high reset
//  op_i         in   1    0 = forward (CIPH_FWD), 1 = inverse (CIPH_INV); sampled at accept
//  in_valid_i   in   1    key_i/op_i valid
//  in_ready_o   out  1    engine idle, can accept
//  key_i        in   128  input key; word wN = [32N+:32]; FIPS byte k at [8k+:8]
//  clear_i      in   1    abort and wipe, any state
//  out_valid_o  out  1    key_o holds result
//  out_ready_i  in   1    consumer accepts result
//  key_o        out  128  result key, same packing as key_i; forced 0 unless out_valid_o
//  busy_o       out  1    high in RUN or DONE
// BEHAVIOUR
//  - Reset: one clk_i edge with rst_i=1 gives state IDLE; key_q, rcon_q, rnd_q = 0.
//    Outputs: in_ready_o=1, out_valid_o=0, key_o=0, busy_o=0.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready_o=1. On an edge with in_valid_i & in_ready_o:
//    - load key_q<=key_i, op_q<=op_i, rnd_q<=0;
//    - load rcon_q<=8'h01 (fwd) or 8'h36 (inv);
//    - go to RUN.
//  - RUN: one round per edge. rnd_q increments 0..9; after the 10th round edge -> DONE.
//    - Latency: out_valid_o rises exactly 10 edges after the accept edge.
//    - in_ready_o=0 in RUN and DONE; in_valid_i is ignored there.
//  - Round function (w0..w3 = key_q words, a3..a0 = bytes of x in bits [31:24]..[7:0]):
//    - f(x) = SubWord({a0,a3,a2,a1}) ^ {24'h0, rcon_q}. Rotate makes byte0 <- byte1.
//    - fwd: w0'=w0^f(w3); w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
//      Update rcon_q <= xtime(rcon_q), poly 0x11b.
//    - inv: u3=w3^w2; u2=w2^w1; u1=w1^w0; u0=w0^f(u3).
//      Update rcon_q <= div2(rcon_q), inverse of xtime.
//    - Rcon sequence per round, fwd: 01,02,04,08,10,20,40,80,1b,36.
//    - Rcon sequence per round, inv: 36,1b,80,40,20,10,08,04,02,01.
//  - DONE: out_valid_o=1, key_o=key_q. Hold both stable until out_ready_i.
//    - On an edge with out_valid_o & out_ready_i: go to IDLE, wipe key_q and rcon_q to 0.
//    - in_ready_o is asserted the cycle after the handshake, so there is a one-cycle
//      gap between jobs.
//  - clear_i, any state, priority over all handshakes:
//    - next edge -> IDLE with key_q, rcon_q, rnd_q = 0;
//    - no out_valid_o is produced for the aborted job;
//    - an in_valid_i in the same cycle is not accepted.
//  - rst_i takes priority over clear_i. Mid-operation reset behaves like clear_i and
//    produces the reset values above.
//  - key_o is AND-gated with out_valid_o, so it never exposes intermediate round keys.
//  - S-box path is purely combinational inside one cycle. No multicycle paths.
// TESTING
//  T1 fwd, FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c (byte string):
//     - out_valid_o 10 edges after accept;
//     - key_o = bytes d014f9a8c9ee2589e13f0cc8b6630ca6.
//  T2 inv: key_i = bytes d014f9a8c9ee2589e13f0cc8b6630ca6, op_i=1
//     -> key_o = bytes 2b7e1516...09cf4f3c after 10 edges.
//  T3 fwd all-zero key -> bytes b4ef5bcb3e92e21123e951cf6f8f188e.
//     Inverse of that result returns all zero.
//  T4 backpressure: out_ready_i low for 5 cycles in DONE.
//     - key_o and out_valid_o stay stable;
//     - in_valid_i pulses during RUN/DONE are ignored;
//     - next accept happens only after the handshake plus one cycle.
//  T5 clear_i at rnd_q=4:
//     - next cycle IDLE, key_o=0, no out_valid_o;
//     - a fresh T1 job then produces the correct result.
//  T6 rst_i asserted at rnd_q=7 with clear_i=1:
//     - reset values on all outputs;
//     - back-to-back fwd then inv jobs return the original key.

Source files
------------

// File: rtl/aes_key_sched_iter_if.sv
// rtl/aes_key_sched_iter_if.sv - request/response bundle for the AES-128 key schedule walker
interface aes_key_sched_iter_if;
  logic         op_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] key_i;
  logic         clear_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] key_o;
  logic         busy_o;

  modport master (
    output op_i, in_valid_i, key_i, clear_i, out_ready_i,
    input  in_ready_o, out_valid_o, key_o, busy_o
  );

  modport slave (
    input  op_i, in_valid_i, key_i, clear_i, out_ready_i,
    output in_ready_o, out_valid_o, key_o, busy_o
  );
endinterface

// File: rtl/aes_key_sched_iter.sv
// rtl/aes_key_sched_iter.sv - iterative AES-128 key schedule walker, cipher key <-> round-10 key
module aes_sbox #(
  parameter string SBoxImpl = "lut"
) (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (i != 0) inv = gf_mul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  if (SBoxImpl == "lut") begin : g_lut
    logic [7:0] w_table [256];
    for (genvar g = 0; g < 256; g++) begin : g_entry
      assign w_table[g] = sbox_calc(8'(g));
    end
    assign o_byte = w_table[i_byte];
  end else begin : g_calc
    assign o_byte = sbox_calc(i_byte);
  end
endmodule

module aes_key_sched_iter #(
  parameter string SBoxImpl = "lut"
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  aes_key_sched_iter_if.slave  bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [127:0] r_key;
  logic [7:0]   r_rcon;
  logic [3:0]   r_rnd;
  logic         r_op;

  logic         w_accept;
  logic         w_release;
  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_busy;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_f_in, w_rot, w_sub, w_f;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [7:0]   w_rcon_fwd, w_rcon_inv;

  assign {w_w3, w_w2, w_w1, w_w0} = r_key;

  // Inverse mode recovers the previous w3 first, since f() of the old w3 undoes w0.
  assign w_f_in = r_op ? (w_w3 ^ w_w2) : w_w3;
  assign w_rot  = {w_f_in[7:0], w_f_in[31:8]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox #(.SBoxImpl(SBoxImpl)) u_sbox (
      .i_byte (w_rot[8*b +: 8]),
      .o_byte (w_sub[8*b +: 8])
    );
  end

  assign w_f = w_sub ^ {24'h0, r_rcon};

  always_comb begin
    if (r_op) begin
      w_n3 = w_w3 ^ w_w2;
      w_n2 = w_w2 ^ w_w1;
      w_n1 = w_w1 ^ w_w0;
      w_n0 = w_w0 ^ w_f;
    end else begin
      w_n0 = w_w0 ^ w_f;
      w_n1 = w_w1 ^ w_n0;
      w_n2 = w_w2 ^ w_n1;
      w_n3 = w_w3 ^ w_n2;
    end
  end

  assign w_rcon_fwd = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  assign w_rcon_inv = {1'b0, r_rcon[7:1]} ^ (r_rcon[0] ? 8'h8d : 8'h00);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b0;
    w_accept     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid_i && !bus.clear_i) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (r_rnd == 4'd9) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready_i && !bus.clear_i) begin
          w_release    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (bus.clear_i) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clear_i) begin
      r_key  <= '0;
      r_rcon <= '0;
      r_rnd  <= '0;
      r_op   <= 1'b0;
    end else if (w_accept) begin
      r_key  <= bus.key_i;
      r_op   <= bus.op_i;
      r_rnd  <= '0;
      r_rcon <= bus.op_i ? 8'h36 : 8'h01;
    end else if (r_state == ST_RUN) begin
      r_key  <= {w_n3, w_n2, w_n1, w_n0};
      r_rcon <= r_op ? w_rcon_inv : w_rcon_fwd;
      r_rnd  <= r_rnd + 4'd1;
    end else if (w_release) begin
      r_key  <= '0;
      r_rcon <= '0;
      r_rnd  <= '0;
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.busy_o      = w_busy;
  assign bus.key_o       = w_out_valid ? r_key : '0;
endmodule

// File: tb/tb_aes_key_sched_iter.sv
// tb/tb_aes_key_sched_iter.sv - bench for aes_key_sched_iter against a FIPS-197 key expansion model
module tb_aes_key_sched_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] m_sbox [256];

  aes_key_sched_iter_if bus ();

  aes_key_sched_iter #(.SBoxImpl("lut")) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic void m_build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      m_sbox[x] = s;
    end
  endfunction

  // Full FIPS-197 expansion of 44 words; the last four are the round-10 key.
  function automatic logic [127:0] m_round10(input logic [127:0] key);
    logic [7:0] w [44][4];
    logic [7:0] t [4];
    logic [7:0] rc;
    logic [7:0] tmp;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
      if (i % 4 == 0) begin
        tmp  = t[0];
        t[0] = m_sbox[t[1]] ^ rc;
        t[1] = m_sbox[t[2]];
        t[2] = m_sbox[t[3]];
        t[3] = m_sbox[tmp];
        rc   = m_mul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) r[8*(4*i+j) +: 8] = w[40+i][j];
    return r;
  endfunction

  function automatic logic [127:0] fips(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = s[127-8*k -: 8];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_k(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_b({tag, "_in_ready"}, bus.in_ready_o, 1'b1);
    check_b({tag, "_out_valid"}, bus.out_valid_o, 1'b0);
    check_k({tag, "_key_o"}, bus.key_o, 128'h0);
    check_b({tag, "_busy"}, bus.busy_o, 1'b0);
  endtask

  task automatic start_job(input string tag, input logic [127:0] key, input logic op);
    int n;
    n = 0;
    while (!bus.in_ready_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_b({tag, "_ready_at_start"}, bus.in_ready_o, 1'b1);
    bus.key_i      = key;
    bus.op_i       = op;
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.key_i      = rnd128();
    bus.op_i       = ~op;
  endtask

  task automatic wait_done(input string tag, input bit poke);
    int lat;
    lat = 0;
    while (!bus.out_valid_o && lat < 20) begin
      if (poke) begin
        bus.in_valid_i = 1'b1;
        bus.key_i      = rnd128();
        bus.op_i       = 1'($urandom());
      end
      @(negedge clk);
      lat++;
    end
    check_i({tag, "_latency"}, lat, 10);
  endtask

  task automatic finish_job(input string tag, input logic [127:0] exp, input int bp, input bit keep_valid);
    logic [127:0] held;
    held = bus.key_o;
    check_k({tag, "_key"}, bus.key_o, exp);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check_b({tag, "_hold_valid"}, bus.out_valid_o, 1'b1);
      check_k({tag, "_hold_key"}, bus.key_o, held);
      check_b({tag, "_hold_not_ready"}, bus.in_ready_o, 1'b0);
    end
    if (!keep_valid) bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    check_idle({tag, "_after_hs"});
  endtask

  initial begin
    logic [127:0] k;
    logic [127:0] k2;
    logic [127:0] key_a1;
    logic [127:0] rk_a1;
    logic [127:0] rk_zero;
    int seen;

    bus.op_i        = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.key_i       = '0;
    bus.clear_i     = 1'b0;
    bus.out_ready_i = 1'b0;
    m_build_sbox();
    key_a1  = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
    rk_a1   = fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rk_zero = fips(128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    rst = 1'b1;
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // T1 / T2 / T3: known vectors both directions
    start_job("t1", key_a1, 1'b0);
    wait_done("t1", 1'b0);
    finish_job("t1", rk_a1, 0, 1'b0);
    start_job("t2", rk_a1, 1'b1);
    wait_done("t2", 1'b0);
    finish_job("t2", key_a1, 0, 1'b0);
    start_job("t3f", 128'h0, 1'b0);
    wait_done("t3f", 1'b0);
    finish_job("t3f", rk_zero, 0, 1'b0);
    start_job("t3i", rk_zero, 1'b1);
    wait_done("t3i", 1'b0);
    finish_job("t3i", 128'h0, 0, 1'b0);

    for (int it = 0; it < 6; it++) begin
      k = rnd128();
      start_job("rnd_fwd", k, 1'b0);
      wait_done("rnd_fwd", 1'b0);
      finish_job("rnd_fwd", m_round10(k), int'($urandom_range(0, 3)), 1'b0);
      start_job("rnd_inv", m_round10(k), 1'b1);
      wait_done("rnd_inv", 1'b0);
      finish_job("rnd_inv", k, int'($urandom_range(0, 3)), 1'b0);
    end

    // T4: backpressure with stray in_valid during RUN and DONE, held across the handshake
    k  = rnd128();
    k2 = rnd128();
    start_job("t4", k, 1'b0);
    wait_done("t4", 1'b1);
    bus.in_valid_i = 1'b1;
    bus.key_i      = k2;
    bus.op_i       = 1'b0;
    finish_job("t4", m_round10(k), 5, 1'b1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    check_b("t4_next_accepted", bus.busy_o, 1'b1);
    wait_done("t4b", 1'b0);
    finish_job("t4b", m_round10(k2), 0, 1'b0);

    // T5: clear at rnd 4, then clear in IDLE masks a simultaneous request
    start_job("t5", key_a1, 1'b0);
    repeat (4) @(negedge clk);
    bus.clear_i    = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.key_i      = rnd128();
    @(negedge clk);
    check_idle("t5_cleared");
    @(negedge clk);
    bus.clear_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    check_b("t5_clear_blocks_accept", bus.busy_o, 1'b0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid_o) seen++;
    end
    check_i("t5_no_out_valid", seen, 0);
    start_job("t5_fresh", key_a1, 1'b0);
    wait_done("t5_fresh", 1'b0);
    finish_job("t5_fresh", rk_a1, 0, 1'b0);

    // T6: reset with clear at rnd 7, then back-to-back fwd/inv round trip
    start_job("t6", rnd128(), 1'b0);
    repeat (7) @(negedge clk);
    rst         = 1'b1;
    bus.clear_i = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    bus.clear_i = 1'b0;
    check_idle("t6_reset");
    k = rnd128();
    start_job("t6_fwd", k, 1'b0);
    wait_done("t6_fwd", 1'b0);
    finish_job("t6_fwd", m_round10(k), 0, 1'b0);
    start_job("t6_inv", m_round10(k), 1'b1);
    wait_done("t6_inv", 1'b0);
    finish_job("t6_inv", k, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
